// File: rtl/push_pkg.sv
// ----------------------------------------------------------------------------
// push_pkg
// Shared types and constants for the push_sequencer grid walker:
//   - state_e      : controller state encoding
//   - DIR_*        : command direction codes carried by cmd_dir
//   - COORD_W      : width of the pos_x / pos_y outputs
//   - CNT_W        : width of the step / hit counters
//   - sat_inc()    : saturating increment used by both counters
// ----------------------------------------------------------------------------
package push_pkg;

    localparam int COORD_W = 3;
    localparam int CNT_W   = 4;

    localparam logic [1:0] DIR_PX = 2'd0;
    localparam logic [1:0] DIR_NX = 2'd1;
    localparam logic [1:0] DIR_PY = 2'd2;
    localparam logic [1:0] DIR_NY = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// ----------------------------------------------------------------------------
// move_fifo
// Synchronous command FIFO, 2-bit entries, DEPTH entries (power of two).
// Ports:
//   clk, clr_n  : clock, asynchronous active-low reset
//   push, din   : write din when push and not full
//   pop         : drop head when pop and not empty
//   flush       : empty the FIFO; overrides push and pop in the same cycle
//   full, empty : occupancy flags decoded from the count register
//   head        : oldest entry (only meaningful when not empty)
// ----------------------------------------------------------------------------
module move_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       push,
    input  logic [1:0] din,
    input  logic       pop,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output logic [1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == {CW{1'b0}});
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/push_sequencer.sv
// ----------------------------------------------------------------------------
// push_sequencer
// Move scheduler / position controller for the grid walker. Buffers direction
// commands, executes at most one per cycle, rejects moves off the grid or into
// the trap cell (with a HIT_STALL-cycle penalty), and ends in DONE on reaching
// the goal or FAIL once MAX_STEPS successful moves have been made.
// Ports:
//   clk, clr_n          : clock, asynchronous active-low reset
//   go                  : start from IDLE / restart from DONE or FAIL
//   cmd_valid, cmd_dir  : command offer (0=+x 1=-x 2=+y 3=-y)
//   cmd_ready           : command accepted when valid & ready
//   pos_x, pos_y        : current position
//   hit                 : one-cycle pulse after a rejected move
//   busy, done, fail    : state flags
//   step_cnt, hit_cnt   : saturating counters
// ----------------------------------------------------------------------------
module push_sequencer
    import push_pkg::*;
#(
    parameter int GRID_W     = 2,
    parameter int GRID_H     = 3,
    parameter int TRAP_X     = 1,
    parameter int TRAP_Y     = 0,
    parameter int GOAL_X     = 1,
    parameter int GOAL_Y     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int HIT_STALL  = 2,
    parameter int MAX_STEPS  = 15
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               go,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_dir,
    output logic               cmd_ready,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               hit,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [CNT_W-1:0]   step_cnt,
    output logic [CNT_W-1:0]   hit_cnt
);

    localparam logic signed [3:0]    GRID_W_S = 4'(GRID_W);
    localparam logic signed [3:0]    GRID_H_S = 4'(GRID_H);
    localparam logic signed [3:0]    TRAP_X_S = 4'(TRAP_X);
    localparam logic signed [3:0]    TRAP_Y_S = 4'(TRAP_Y);
    localparam logic [COORD_W-1:0]   GOAL_X_C = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0]   GOAL_Y_C = COORD_W'(GOAL_Y);
    localparam logic [CNT_W-1:0]     MAX_C    = CNT_W'(MAX_STEPS);
    // Stall counter is loaded with HIT_STALL-1 so RUN resumes exactly HIT_STALL cycles later.
    localparam logic [CNT_W-1:0]     STALL_LD = CNT_W'(HIT_STALL - 1);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   pos_x_q, pos_x_d;
    logic [COORD_W-1:0]   pos_y_q, pos_y_d;
    logic [CNT_W-1:0]     step_q, step_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     stall_q, stall_d;
    logic                 hit_q, hit_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [1:0]           head_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 flush_s;
    logic signed [3:0]    tx_s;
    logic signed [3:0]    ty_s;
    logic                 reject_s;

    // cmd_ready depends only on registered count and state, never on cmd_*.
    assign cmd_ready = !fifo_full_s && (state_q != ST_DONE) && (state_q != ST_FAIL);
    assign push_s    = cmd_valid && cmd_ready;

    move_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (push_s),
        .din   (cmd_dir),
        .pop   (pop_s),
        .flush (flush_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s)
    );

    // Target cell of the head command and its legality, one sign bit of headroom.
    always_comb begin
        tx_s = signed'({1'b0, pos_x_q});
        ty_s = signed'({1'b0, pos_y_q});
        case (head_s)
            DIR_PX:  tx_s = tx_s + 4'sd1;
            DIR_NX:  tx_s = tx_s - 4'sd1;
            DIR_PY:  ty_s = ty_s + 4'sd1;
            DIR_NY:  ty_s = ty_s - 4'sd1;
            default: tx_s = tx_s;
        endcase
        reject_s = (tx_s < 4'sd0) || (ty_s < 4'sd0) ||
                   (tx_s >= GRID_W_S) || (ty_s >= GRID_H_S) ||
                   ((tx_s == TRAP_X_S) && (ty_s == TRAP_Y_S));
    end

    // Controller next-state, position and counter updates.
    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        step_d    = step_q;
        hit_cnt_d = hit_cnt_q;
        stall_d   = stall_q;
        hit_d     = 1'b0;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (reject_s) begin
                        hit_d     = 1'b1;
                        hit_cnt_d = sat_inc(hit_cnt_q);
                        stall_d   = STALL_LD;
                        state_d   = ST_STALL;
                    end else begin
                        pos_x_d = tx_s[COORD_W-1:0];
                        pos_y_d = ty_s[COORD_W-1:0];
                        step_d  = sat_inc(step_q);
                        // Reaching the goal wins over running out of budget on the same move.
                        if ((pos_x_d == GOAL_X_C) && (pos_y_d == GOAL_Y_C)) begin
                            state_d = ST_DONE;
                        end else if (step_d >= MAX_C) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                if (stall_q == {CNT_W{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    stall_d = stall_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE, ST_FAIL: begin
                if (go) begin
                    state_d   = ST_IDLE;
                    pos_x_d   = {COORD_W{1'b0}};
                    pos_y_d   = {COORD_W{1'b0}};
                    step_d    = {CNT_W{1'b0}};
                    hit_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Terminal states drop any queued commands, including a push in the entry cycle.
        if ((state_d == ST_DONE) || (state_d == ST_FAIL)) begin
            flush_s = 1'b1;
        end else begin
            flush_s = 1'b0;
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_STALL);
        done_d = (state_d == ST_DONE);
        fail_d = (state_d == ST_FAIL);
    end

    // Controller registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            pos_x_q   <= {COORD_W{1'b0}};
            pos_y_q   <= {COORD_W{1'b0}};
            step_q    <= {CNT_W{1'b0}};
            hit_cnt_q <= {CNT_W{1'b0}};
            stall_q   <= {CNT_W{1'b0}};
            hit_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            step_q    <= step_d;
            hit_cnt_q <= hit_cnt_d;
            stall_q   <= stall_d;
            hit_q     <= hit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign hit      = hit_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign step_cnt = step_q;
    assign hit_cnt  = hit_cnt_q;

endmodule
